// File: rtl/risc_v_32_pkg.sv
// rtl/risc_v_32_pkg.sv - shared RV32 LSU encodings, state enum and byte-enable helper
package risc_v_32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_32_load_ext.sv
// rtl/risc_v_32_load_ext.sv - load lane select with sign/zero extension
module risc_v_32_load_ext
  import risc_v_32_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    case (i_funct3)
      F3_B:    o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_result = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_result = {16'h0000, w_shifted[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/risc_v_32_lsu.sv
// rtl/risc_v_32_lsu.sv - RV32 MEM-stage load/store unit with req/ack data-memory port
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of aligning them.
module risc_v_32_lsu
  import risc_v_32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_out_valid,
  output logic              misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack
);

  lsu_state_t        r_state;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              r_is_load;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem_out;
  logic              r_mem_out_valid;
  logic              r_misalign;

  logic              w_start;
  logic              w_trap;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ext;

  assign w_start = ex_valid & (mem_read | mem_write);
  assign w_size  = funct3[1:0];

  // Offending low bits are dropped so a misaligned H/W still hits its own word.
  always_comb begin
    w_off   = addr[1:0];
    w_wdata = store_data;
    case (w_size)
      SZ_B: begin
        w_wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        w_off   = {addr[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_off = 2'b00;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_size == SZ_H) ? addr[0] :
                  (w_size != SZ_B) ? (addr[1:0] != 2'b00) : 1'b0;
`else
  assign w_trap = 1'b0;
`endif

  risc_v_32_load_ext u_load_ext (
    .i_rdata  (dmem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_result (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_off           <= 2'b00;
      r_funct3        <= 3'b000;
      r_is_load       <= 1'b0;
      r_req           <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_be            <= '0;
      r_wdata         <= '0;
      r_mem_out       <= '0;
      r_mem_out_valid <= 1'b0;
      r_misalign      <= 1'b0;
    end else begin
      r_mem_out_valid <= 1'b0;
      r_misalign      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_off     <= w_off;
            r_funct3  <= funct3;
            r_is_load <= ~mem_write;
            if (w_trap) begin
              r_misalign <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_req   <= 1'b1;
              r_we    <= mem_write;
              r_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_be    <= byte_en(w_size, w_off);
              r_wdata <= w_wdata;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_is_load) begin
              r_mem_out       <= w_ext;
              r_mem_out_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the freeze releases the instant reset asserts.
  assign stall = rst_n & (((r_state == ST_IDLE) & w_start) | (r_state == ST_REQ));

  assign mem_out       = r_mem_out;
  assign mem_out_valid = r_mem_out_valid;
  assign misalign      = r_misalign;
  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_be       = r_be;
  assign dmem_wdata    = r_wdata;

endmodule

// File: tb/tb_risc_v_32_lsu.sv
// tb/tb_risc_v_32_lsu.sv - directed self-checking bench for risc_v_32_lsu
module tb_risc_v_32_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic        misalign;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt;

  risc_v_32_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .mem_out       (mem_out),
    .mem_out_valid (mem_out_valid),
    .misalign      (misalign),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    ex_valid   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    dmem_ack  = 1'b0;
  endtask

  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_out);
    issue(1'b1, 1'b0, f3, a, 32'h0);
    check({tag, " stall_T"}, stall, 1);
    check({tag, " req_T"}, dmem_req, 0);
    tick();
    check({tag, " req_T1"}, dmem_req, 1);
    check({tag, " we_T1"}, dmem_we, 0);
    check({tag, " addr"}, dmem_addr, exp_addr);
    check({tag, " be"}, dmem_be, exp_be);
    check({tag, " stall_T1"}, stall, 1);
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    tick();
    check({tag, " valid_T2"}, mem_out_valid, 1);
    check({tag, " mem_out"}, mem_out, exp_out);
    check({tag, " stall_T2"}, stall, 0);
    check({tag, " req_T2"}, dmem_req, 0);
    idle_inputs();
    tick();
    check({tag, " valid_T3"}, mem_out_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    dmem_rdata = 32'h0;
    idle_inputs();
    tick();
    tick();
    check("rst stall", stall, 0);
    check("rst req", dmem_req, 0);
    check("rst we", dmem_we, 0);
    check("rst valid", mem_out_valid, 0);
    check("rst misalign", misalign, 0);
    check("rst addr", dmem_addr, 0);
    check("rst be", dmem_be, 0);
    check("rst wdata", dmem_wdata, 0);
    check("rst mem_out", mem_out, 0);
    rst_n = 1'b1;
    tick();

    load_txn("LW100", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
    load_txn("LB103", 3'b000, 32'h103, 32'h80112233, 32'h100, 4'b1000, 32'hFFFFFF80);
    load_txn("LBU103", 3'b100, 32'h103, 32'h80112233, 32'h100, 4'b1000, 32'h00000080);
    load_txn("LH102", 3'b001, 32'h102, 32'h80112233, 32'h100, 4'b1100, 32'hFFFF8011);
    load_txn("LHU102", 3'b101, 32'h102, 32'h80112233, 32'h100, 4'b1100, 32'h00008011);
    load_txn("LB101", 3'b000, 32'h101, 32'h80112233, 32'h100, 4'b0010, 32'h00000022);

    // SB at 0x201: byte lane 1 only
    issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB);
    check("SB stall_T", stall, 1);
    tick();
    check("SB req", dmem_req, 1);
    check("SB we", dmem_we, 1);
    check("SB addr", dmem_addr, 32'h200);
    check("SB be", dmem_be, 4'b0010);
    check("SB byte1", dmem_wdata[15:8], 8'hAB);
    dmem_ack = 1'b1;
    tick();
    check("SB valid", mem_out_valid, 0);
    check("SB mem_out kept", mem_out, 32'h00000022);
    check("SB stall_T2", stall, 0);
    idle_inputs();
    tick();

    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF);
    tick();
    check("SH be", dmem_be, 4'b1100);
    check("SH hi half", dmem_wdata[31:16], 16'hBEEF);
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // read+write together behaves as a store
    issue(1'b1, 1'b1, 3'b010, 32'h204, 32'h12345678);
    tick();
    check("RW we", dmem_we, 1);
    check("RW be", dmem_be, 4'b1111);
    check("RW wdata", dmem_wdata, 32'h12345678);
    dmem_rdata = 32'h55555555;
    dmem_ack   = 1'b1;
    tick();
    check("RW valid", mem_out_valid, 0);
    check("RW mem_out kept", mem_out, 32'h00000022);
    idle_inputs();
    tick();

    // ack outside REQ does nothing
    dmem_ack = 1'b1;
    tick();
    tick();
    check("stray ack req", dmem_req, 0);
    check("stray ack valid", mem_out_valid, 0);
    dmem_ack = 1'b0;
    tick();

    // ack after five REQ cycles
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    stall_cnt = int'(stall);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("WAIT req", dmem_req, 1);
      check("WAIT addr", dmem_addr, 32'h300);
      check("WAIT be", dmem_be, 4'b1111);
      stall_cnt += int'(stall);
      if (i == 5) begin
        dmem_rdata = 32'hCAFEF00D;
        dmem_ack   = 1'b1;
      end
    end
    tick();
    check("WAIT stall cycles", stall_cnt, 6);
    check("WAIT valid", mem_out_valid, 1);
    check("WAIT mem_out", mem_out, 32'hCAFEF00D);
    check("WAIT stall_done", stall, 0);
    check("WAIT req_done", dmem_req, 0);
    dmem_ack = 1'b0;
    tick();
    check("WAIT valid once", mem_out_valid, 0);
    check("WAIT no reissue", dmem_req, 0);
    idle_inputs();
    tick();

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    tick();
    check("MIS req", dmem_req, 0);
    check("MIS misalign", misalign, 1);
    check("MIS valid", mem_out_valid, 0);
    check("MIS mem_out kept", mem_out, 32'hCAFEF00D);
    idle_inputs();
    tick();
    check("MIS pulse", misalign, 0);
    tick();
`else
    load_txn("LWMIS102", 3'b010, 32'h102, 32'h11223344, 32'h100, 4'b1111, 32'h11223344);
    check("LWMIS misalign", misalign, 0);
    load_txn("LHMIS103", 3'b001, 32'h103, 32'h80112233, 32'h100, 4'b1100, 32'hFFFF8011);
`endif

    // reset while in REQ
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    check("RST req before", dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("RST req async", dmem_req, 0);
    check("RST stall async", stall, 0);
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    check("RST valid", mem_out_valid, 0);
    check("RST mem_out", mem_out, 0);
    tick();
    load_txn("LWpost", 3'b010, 32'h400, 32'h0BADF00D, 32'h400, 4'b1111, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
